cacc_dump: RTL

Complex accumulate-and-dump stage placed directly downstream of the complex multiplier. It takes a stream of full-precision complex products and sums N consecutive valid products per frame, where N is set at run time. At each frame end it emits one rounded, saturated complex result with an overflow flag. Typical uses are correlator/despreader integration and decimating channel estimation.

---
 rtl/cacc_dump_pkg.sv | 45 ++++
 rtl/round_sat.sv | 38 +++
 rtl/cacc_dump.sv | 106 ++++++++++
 3 files changed

// File: rtl/cacc_dump_pkg.sv
// Shared DSP helpers: accumulator width derivation and the round-half-up /
// saturate function used by accumulate-and-dump, decimator and scaler blocks.
package cacc_dump_pkg;

  localparam int unsigned RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   sat;
  } rs_t;

  function automatic int unsigned accw(input int unsigned iw, input int unsigned cw);
    return iw + cw;
  endfunction

  // Operates on a 64-bit signed container so one helper serves every width.
  function automatic rs_t round_sat_f(input logic signed [RS_W-1:0] x,
                                      input int unsigned shift,
                                      input int unsigned out_w);
    logic signed [RS_W-1:0] rnd;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t res;
    rnd = '0;
    if (shift > 0) rnd[shift-1] = 1'b1;
    r = x + rnd;
    r = r >>> shift;
    hi = '0;
    for (int unsigned i = 0; i < out_w - 1; i++) hi[i] = 1'b1;
    lo = ~hi;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/round_sat.sv
// Registered round-half-up, arithmetic shift and saturation of one signed
// component; output and sat flag update only when en is high.
module round_sat
  import cacc_dump_pkg::*;
#(
  parameter int unsigned IN_W  = 43,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  rs_t  rs;
  logic unused_hi;

  always_comb begin
    rs = round_sat_f(RS_W'(din), SHIFT, OUT_W);
  end

  // Upper container bits are always a sign copy after clamping.
  assign unused_hi = ^rs.val[RS_W-1:OUT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (en) begin
      dout <= rs.val[OUT_W-1:0];
      sat  <= rs.sat;
    end
  end

endmodule

// File: rtl/cacc_dump.sv
// Complex accumulate-and-dump: sums N valid products per frame, then emits one
// rounded, saturated complex result with an overflow flag.
module cacc_dump
  import cacc_dump_pkg::*;
#(
  parameter int unsigned IWIDTH = 35,
  parameter int unsigned CWIDTH = 8,
  parameter int unsigned OWIDTH = 24,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [IWIDTH-1:0] in_re,
  input  logic signed [IWIDTH-1:0] in_im,
  input  logic [CWIDTH-1:0]        dump_len,
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] out_re,
  output logic signed [OWIDTH-1:0] out_im,
  output logic                     out_ovf
);

  localparam int unsigned ACCW = accw(IWIDTH, CWIDTH);

  logic [CWIDTH-1:0]      cnt;
  logic [CWIDTH-1:0]      len_q;
  logic signed [ACCW-1:0] acc_re;
  logic signed [ACCW-1:0] acc_im;
  logic signed [ACCW-1:0] sum_re_q;
  logic signed [ACCW-1:0] sum_im_q;
  logic                   dump_v;

  logic                   first;
  logic                   last;
  logic [CWIDTH-1:0]      cur_len;
  logic signed [ACCW-1:0] ext_re;
  logic signed [ACCW-1:0] ext_im;
  logic signed [ACCW-1:0] acc_re_nx;
  logic signed [ACCW-1:0] acc_im_nx;
  logic                   sat_re;
  logic                   sat_im;

  // The frame's first sample uses the live dump_len, later ones the latched copy.
  always_comb begin
    first     = (cnt == '0);
    cur_len   = first ? dump_len : len_q;
    last      = (cnt == cur_len);
    ext_re    = ACCW'(in_re);
    ext_im    = ACCW'(in_im);
    acc_re_nx = first ? ext_re : acc_re + ext_re;
    acc_im_nx = first ? ext_im : acc_im + ext_im;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      len_q    <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      dump_v   <= 1'b0;
    end else begin
      dump_v <= 1'b0;
      if (in_valid) begin
        acc_re <= acc_re_nx;
        acc_im <= acc_im_nx;
        if (first) len_q <= dump_len;
        if (last) begin
          sum_re_q <= acc_re_nx;
          sum_im_q <= acc_im_nx;
          dump_v   <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CWIDTH'(1);
        end
      end
    end
  end

  round_sat #(.IN_W(ACCW), .OUT_W(OWIDTH), .SHIFT(SHIFT)) u_rs_re (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dump_v),
    .din   (sum_re_q),
    .dout  (out_re),
    .sat   (sat_re)
  );

  round_sat #(.IN_W(ACCW), .OUT_W(OWIDTH), .SHIFT(SHIFT)) u_rs_im (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dump_v),
    .din   (sum_im_q),
    .dout  (out_im),
    .sat   (sat_im)
  );

  assign out_ovf = sat_re | sat_im;

  always_ff @(posedge clk) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= dump_v;
  end

endmodule
